exe_stage: RTL and testbench

Execute stage of the 5-stage pipeline. It sits between the decode stage and the memory stage and latches the 148-bit decode-to-execute bus under a valid/allowin handshake. It computes the 12-op one-hot ALU result and issues the data SRAM request for ld.w/st.w. It also returns forwarding and load-use information to decode every cycle.

---
 rtl/exe_stage.sv | 98 +++++++++
 tb/tb_exe_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: latches the decode bus, computes the ALU result, issues data SRAM requests, reports forwarding/load-use to decode.
// Latency: one cycle; an instruction accepted at edge N is presented to the memory stage from N until it leaves.
// Backpressure: ms_allowin=0 holds the latched instruction and drops es_allowin; stores write only in the release cycle.
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ds2es_valid,
    output logic         es_allowin,
    input  logic [147:0] ds2es_bus,
    input  logic         ms_allowin,
    output logic         es2ms_valid,
    output logic [70:0]  es2ms_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         exe_rf_we,
    output logic [4:0]   exe_dest,
    output logic [31:0]  alu_result,
    output logic         es_inst_is_ld_w
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_src1;
        logic [31:0] alu_src2;
        logic [11:0] alu_op;
        logic [31:0] rkd_value;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic        mem_we;
    } ds2es_t;

    logic   es_valid;
    ds2es_t es_bus;
    logic   es_ready_go;

    assign es_ready_go = 1'b1;
    assign es_allowin  = ~es_valid | (es_ready_go & ms_allowin);
    assign es2ms_valid = es_valid & es_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid <= 1'b0;
            es_bus   <= '0;
        end else if (es_allowin) begin
            es_valid <= ds2es_valid;
            if (ds2es_valid) begin
                es_bus <= ds2es_t'(ds2es_bus);
            end
        end
    end

    logic [31:0] src1;
    logic [31:0] src2;
    logic [11:0] op;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        slt_lt;
    logic        sltu_lt;

    assign src1    = es_bus.alu_src1;
    assign src2    = es_bus.alu_src2;
    assign op      = es_bus.alu_op;
    assign sum     = src1 + src2;
    assign diff    = src1 - src2;
    assign slt_lt  = $signed(src1) < $signed(src2);
    assign sltu_lt = src1 < src2;

    // One-hot select as an AND-OR mux; an all-zero op falls out as zero.
    always_comb begin
        alu_result = 32'b0;
        if (op[0])  alu_result = alu_result | sum;
        if (op[1])  alu_result = alu_result | diff;
        if (op[2])  alu_result = alu_result | {31'b0, slt_lt};
        if (op[3])  alu_result = alu_result | {31'b0, sltu_lt};
        if (op[4])  alu_result = alu_result | (src1 & src2);
        if (op[5])  alu_result = alu_result | ~(src1 | src2);
        if (op[6])  alu_result = alu_result | (src1 | src2);
        if (op[7])  alu_result = alu_result | (src1 ^ src2);
        if (op[8])  alu_result = alu_result | (src1 << src2[4:0]);
        if (op[9])  alu_result = alu_result | (src1 >> src2[4:0]);
        if (op[10]) alu_result = alu_result | 32'($signed(src1) >>> src2[4:0]);
        if (op[11]) alu_result = alu_result | src2;
    end

    assign es2ms_bus       = {es_bus.pc, alu_result, es_bus.res_from_mem, es_bus.gr_we, es_bus.dest};
    assign data_sram_en    = es_valid & (es_bus.res_from_mem | es_bus.mem_we);
    assign data_sram_we    = {4{es_valid & es_bus.mem_we & ms_allowin}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = es_bus.rkd_value;

    assign exe_rf_we       = es_valid & es_bus.gr_we;
    assign exe_dest        = es_bus.dest;
    assign es_inst_is_ld_w = es_valid & es_bus.res_from_mem;

endmodule

// File: tb/tb_exe_stage.sv
// Directed testbench for exe_stage: reset, ALU ops, store stall, load-use strobes, back-to-back stream.
module tb_exe_stage;

    logic         clk;
    logic         reset;
    logic         ds2es_valid;
    logic         es_allowin;
    logic [147:0] ds2es_bus;
    logic         ms_allowin;
    logic         es2ms_valid;
    logic [70:0]  es2ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         exe_rf_we;
    logic [4:0]   exe_dest;
    logic [31:0]  alu_result;
    logic         es_inst_is_ld_w;

    int tests;
    int fails;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ds2es_valid     (ds2es_valid),
        .es_allowin      (es_allowin),
        .ds2es_bus       (ds2es_bus),
        .ms_allowin      (ms_allowin),
        .es2ms_valid     (es2ms_valid),
        .es2ms_bus       (es2ms_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .exe_rf_we       (exe_rf_we),
        .exe_dest        (exe_dest),
        .alu_result      (alu_result),
        .es_inst_is_ld_w (es_inst_is_ld_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [147:0] make_bus(
        input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2,
        input logic [11:0] op, input logic [31:0] rkd, input logic rfm,
        input logic gwe, input logic [4:0] dst, input logic mwe);
        return {pc, s1, s2, op, rkd, rfm, gwe, dst, mwe};
    endfunction

    // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        ms_allowin  = 1'b1;
        ds2es_valid = 1'b1;
        ds2es_bus   = make_bus(32'h1c000000, 32'h1, 32'h2, 12'h001, 32'h0, 1'b0, 1'b1, 5'd3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (es2ms_valid !== 1'b0 || es_allowin !== 1'b1 || data_sram_we !== 4'h0) begin
                fails++;
                $display("FAIL reset_strobes cyc%0d: valid=%b allowin=%b we=%h, want 0 1 0",
                         i, es2ms_valid, es_allowin, data_sram_we);
            end
            tests++;
            if (es2ms_bus !== 71'b0 || alu_result !== 32'b0 || exe_rf_we !== 1'b0 || data_sram_en !== 1'b0) begin
                fails++;
                $display("FAIL reset_bus cyc%0d: bus=%h alu=%h rf_we=%b en=%b, want all 0",
                         i, es2ms_bus, alu_result, exe_rf_we, data_sram_en);
            end
        end
        reset = 1'b0;
        #1;
        tests++;
        if (es2ms_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_before_edge: valid=%b want 0", es2ms_valid);
        end
        step();
        tests++;
        if (es2ms_valid !== 1'b1 || es2ms_bus[38:7] !== 32'h3) begin
            fails++;
            $display("FAIL reset_first_accept: valid=%b alu=%h, want 1 00000003", es2ms_valid, es2ms_bus[38:7]);
        end
        ds2es_valid = 1'b0;
        step();
    endtask

    task automatic test_add();
        ds2es_valid = 1'b1;
        ds2es_bus   = make_bus(32'h1c000010, 32'h7fffffff, 32'h1, 12'h001, 32'h0, 1'b0, 1'b1, 5'd5, 1'b0);
        step();
        ds2es_valid = 1'b0;
        tests++;
        if (es2ms_valid !== 1'b1 || es2ms_bus[38:7] !== 32'h80000000 || es2ms_bus[70:39] !== 32'h1c000010) begin
            fails++;
            $display("FAIL add_result: valid=%b alu=%h pc=%h, want 1 80000000 1c000010",
                     es2ms_valid, es2ms_bus[38:7], es2ms_bus[70:39]);
        end
        tests++;
        if (exe_rf_we !== 1'b1 || exe_dest !== 5'd5 || es2ms_bus[5] !== 1'b1 || es2ms_bus[4:0] !== 5'd5) begin
            fails++;
            $display("FAIL add_forward: rf_we=%b dest=%0d bus_gwe=%b bus_dest=%0d, want 1 5 1 5",
                     exe_rf_we, exe_dest, es2ms_bus[5], es2ms_bus[4:0]);
        end
        step();
        tests++;
        if (es2ms_valid !== 1'b0 || exe_rf_we !== 1'b0) begin
            fails++;
            $display("FAIL add_drain: valid=%b rf_we=%b, want 0 0", es2ms_valid, exe_rf_we);
        end
    endtask

    task automatic test_alu_ops();
        logic [11:0] ops [0:11];
        logic [31:0] s1  [0:11];
        logic [31:0] s2  [0:11];
        logic [31:0] exp [0:11];
        ops = '{12'h004, 12'h008, 12'h400, 12'h200, 12'h000, 12'h002,
                12'h020, 12'h800, 12'h100, 12'h010, 12'h040, 12'h080};
        s1  = '{32'hffffffff, 32'hffffffff, 32'h80000000, 32'h80000000, 32'h12345678, 32'h5,
                32'h0, 32'hdeadbeef, 32'h1, 32'hf0f0ff00, 32'hf0f00000, 32'hffff0000};
        s2  = '{32'h1, 32'h1, 32'h4, 32'h4, 32'h11111111, 32'h7,
                32'h0, 32'h12345000, 32'h1f, 32'h0ff00ff0, 32'h00000f0f, 32'h0ff00ff0};
        exp = '{32'h1, 32'h0, 32'hf8000000, 32'h08000000, 32'h0, 32'hfffffffe,
                32'hffffffff, 32'h12345000, 32'h80000000, 32'h00f00f00, 32'hf0f00f0f, 32'hf00f0ff0};
        for (int i = 0; i < 12; i++) begin
            ds2es_valid = 1'b1;
            ds2es_bus   = make_bus(32'h1c000100 + 32'(i * 4), s1[i], s2[i], ops[i], 32'h0, 1'b0, 1'b1, 5'd1, 1'b0);
            step();
            tests++;
            if (es2ms_valid !== 1'b1 || alu_result !== exp[i] || es2ms_bus[38:7] !== exp[i]) begin
                fails++;
                $display("FAIL alu_op_%03h #%0d: valid=%b alu=%h bus_alu=%h, want 1 %h",
                         ops[i], i, es2ms_valid, alu_result, es2ms_bus[38:7], exp[i]);
            end
        end
        ds2es_valid = 1'b0;
        step();
    endtask

    task automatic test_store_stall();
        ds2es_valid = 1'b1;
        ms_allowin  = 1'b0;
        ds2es_bus   = make_bus(32'h1c000200, 32'h1000, 32'h8, 12'h001, 32'hdeadbeef, 1'b0, 1'b0, 5'd0, 1'b1);
        step();
        ds2es_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (es_allowin !== 1'b0 || data_sram_we !== 4'h0 || data_sram_en !== 1'b1 || es2ms_valid !== 1'b1) begin
                fails++;
                $display("FAIL store_stall cyc%0d: allowin=%b we=%h en=%b valid=%b, want 0 0 1 1",
                         i, es_allowin, data_sram_we, data_sram_en, es2ms_valid);
            end
            tests++;
            if (data_sram_addr !== 32'h1008 || data_sram_wdata !== 32'hdeadbeef) begin
                fails++;
                $display("FAIL store_addr cyc%0d: addr=%h wdata=%h, want 00001008 deadbeef",
                         i, data_sram_addr, data_sram_wdata);
            end
            if (i < 2) step();
        end
        ms_allowin = 1'b1;
        #1;
        tests++;
        if (data_sram_we !== 4'hf || es_allowin !== 1'b1 || data_sram_addr !== 32'h1008) begin
            fails++;
            $display("FAIL store_release: we=%h allowin=%b addr=%h, want f 1 00001008",
                     data_sram_we, es_allowin, data_sram_addr);
        end
        step();
        tests++;
        if (data_sram_we !== 4'h0 || data_sram_en !== 1'b0 || es2ms_valid !== 1'b0) begin
            fails++;
            $display("FAIL store_after: we=%h en=%b valid=%b, want 0 0 0", data_sram_we, data_sram_en, es2ms_valid);
        end
    endtask

    task automatic test_load();
        ds2es_valid = 1'b1;
        ds2es_bus   = make_bus(32'h1c000300, 32'h2000, 32'h4, 12'h001, 32'h0, 1'b1, 1'b1, 5'd7, 1'b0);
        step();
        ds2es_valid = 1'b0;
        tests++;
        if (es_inst_is_ld_w !== 1'b1 || data_sram_en !== 1'b1 || data_sram_we !== 4'h0 || data_sram_addr !== 32'h2004) begin
            fails++;
            $display("FAIL load_in_ex: ld_w=%b en=%b we=%h addr=%h, want 1 1 0 00002004",
                     es_inst_is_ld_w, data_sram_en, data_sram_we, data_sram_addr);
        end
        step();
        tests++;
        if (es_inst_is_ld_w !== 1'b0 || exe_rf_we !== 1'b0 || data_sram_en !== 1'b0) begin
            fails++;
            $display("FAIL load_bubble: ld_w=%b rf_we=%b en=%b, want 0 0 0", es_inst_is_ld_w, exe_rf_we, data_sram_en);
        end
    endtask

    task automatic test_back_to_back();
        ds2es_valid = 1'b1;
        ds2es_bus   = make_bus(32'h1c000400, 32'h10, 32'h0, 12'h001, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (es2ms_valid !== 1'b1 || es2ms_bus[70:39] !== 32'h1c000400 + 32'(i * 4)
                || es2ms_bus[38:7] !== 32'h10 + 32'(i) || es_allowin !== 1'b1) begin
                fails++;
                $display("FAIL b2b #%0d: valid=%b pc=%h alu=%h allowin=%b, want 1 %h %h 1", i, es2ms_valid,
                         es2ms_bus[70:39], es2ms_bus[38:7], es_allowin, 32'h1c000400 + 32'(i * 4), 32'h10 + 32'(i));
            end
            ds2es_bus = make_bus(32'h1c000404 + 32'(i * 4), 32'h11 + 32'(i), 32'h0, 12'h001,
                                 32'h0, 1'b0, 1'b1, 5'd0, 1'b0);
        end
        reset = 1'b1;
        step();
        tests++;
        if (es2ms_valid !== 1'b0 || es_allowin !== 1'b1 || es2ms_bus !== 71'b0) begin
            fails++;
            $display("FAIL b2b_reset: valid=%b allowin=%b bus=%h, want 0 1 0", es2ms_valid, es_allowin, es2ms_bus);
        end
        reset       = 1'b0;
        ds2es_valid = 1'b0;
        step();
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        ds2es_valid = 1'b0;
        ds2es_bus   = '0;
        ms_allowin  = 1'b1;
        test_reset();
        test_add();
        test_alu_ops();
        test_store_stall();
        test_load();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
